// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: qualifies PLL lock, retries the PLL on lock timeout and releases domain resets in order.
// Defining RSTSEQ_RETRY_LIMIT_EN adds a retry limit: after MAX_RETRIES timeouts the FSM parks in FAIL.
`timescale 1ns/1ps
module pll_reset_seq #(
  parameter int SYNC_STAGES        = 2,
  parameter int PLL_RST_CYCLES     = 50,
  parameter int LOCK_TIMEOUT       = 50000,
  parameter int LOCK_STABLE_CYCLES = 5000,
  parameter int RELEASE_GAP        = 16,
  parameter int NUM_DOMAINS        = 3,
  parameter int MAX_RETRIES        = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   lock,
  output logic                   pll_reset,
  output logic [NUM_DOMAINS-1:0] sys_reset,
  output logic                   ready,
  output logic [7:0]             retry_count,
  output logic [7:0]             lock_loss_count,
  output logic                   fail
);

  localparam int REL_SPAN = RELEASE_GAP * NUM_DOMAINS;
  localparam int MAX_A    = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_B    = (LOCK_STABLE_CYCLES > REL_SPAN) ? LOCK_STABLE_CYCLES : REL_SPAN;
  localparam int CNT_MAX  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W    = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(REL_SPAN - 1);
`ifdef RSTSEQ_RETRY_LIMIT_EN
  localparam logic [7:0]       RETRY_LAST   = 8'(MAX_RETRIES - 1);
`endif

  if (SYNC_STAGES < 2 || MAX_RETRIES < 1) begin : g_param_check
    $error("pll_reset_seq: SYNC_STAGES must be >= 2 and MAX_RETRIES >= 1");
  end

  typedef enum logic [2:0] {
    ST_PLL_RST,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RELEASE,
    ST_RUN
`ifdef RSTSEQ_RETRY_LIMIT_EN
    , ST_FAIL
`endif
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   lock_s;
  logic [NUM_DOMAINS-1:0] sys_reset_d;
  logic [7:0]             retry_d, loss_d;
  logic                   pll_reset_d, ready_d;

  // lock synchroniser: lock_s is the only view of lock used by the FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lock_sync <= '0;
    else       lock_sync <= {lock_sync[SYNC_STAGES-2:0], lock};
  end
  assign lock_s = lock_sync[SYNC_STAGES-1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    sys_reset_d = sys_reset;
    retry_d     = retry_count;
    loss_d      = lock_loss_count;
    unique case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == PLL_RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = sat_inc(retry_count);
          state_d = ST_PLL_RST;
`ifdef RSTSEQ_RETRY_LIMIT_EN
          if (retry_count == RETRY_LAST) state_d = ST_FAIL;
`endif
        end
      end
      ST_STABLE: begin
        if (!lock_s)                   state_d = ST_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = ST_RELEASE;
      end
      ST_RELEASE, ST_RUN: begin
        // lock loss outranks a release edge; the PLL relocks on its own, so no PLL reset
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          loss_d  = sat_inc(lock_loss_count);
        end else if (state_q == ST_RELEASE) begin
          for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (cnt_q == CNT_W'((i + 1) * RELEASE_GAP - 1)) sys_reset_d[i] = 1'b0;
          end
          if (cnt_q == RELEASE_LAST) state_d = ST_RUN;
        end
      end
`ifdef RSTSEQ_RETRY_LIMIT_EN
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
`endif
      default: state_d = ST_PLL_RST;
    endcase
    if (state_d != state_q) cnt_d = '0;
    if (state_d != ST_RELEASE && state_d != ST_RUN) sys_reset_d = '1;
    pll_reset_d = (state_d == ST_PLL_RST);
`ifdef RSTSEQ_RETRY_LIMIT_EN
    if (state_d == ST_FAIL) pll_reset_d = 1'b1;
`endif
    ready_d = (state_d == ST_RUN);
  end

  // all outputs are registered from the next-state decision
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_PLL_RST;
      cnt_q           <= '0;
      pll_reset       <= 1'b1;
      sys_reset       <= '1;
      ready           <= 1'b0;
      retry_count     <= 8'd0;
      lock_loss_count <= 8'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pll_reset       <= pll_reset_d;
      sys_reset       <= sys_reset_d;
      ready           <= ready_d;
      retry_count     <= retry_d;
      lock_loss_count <= loss_d;
    end
  end

`ifdef RSTSEQ_RETRY_LIMIT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fail <= 1'b0;
    else       fail <= (state_d == ST_FAIL);
  end
`else
  assign fail = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq using the reduced simulation parameters.
`timescale 1ns/1ps
module tb_pll_reset_seq;

  localparam int ND = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          lock = 1'b0;
  logic          pll_reset;
  logic [ND-1:0] sys_reset;
  logic          ready;
  logic [7:0]    retry_count;
  logic [7:0]    lock_loss_count;
  logic          fail;

  int n_tests = 0;
  int n_fail  = 0;

  pll_reset_seq #(
    .SYNC_STAGES        (2),
    .PLL_RST_CYCLES     (4),
    .LOCK_TIMEOUT       (32),
    .LOCK_STABLE_CYCLES (8),
    .RELEASE_GAP        (4),
    .NUM_DOMAINS        (ND),
    .MAX_RETRIES        (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .lock            (lock),
    .pll_reset       (pll_reset),
    .sys_reset       (sys_reset),
    .ready           (ready),
    .retry_count     (retry_count),
    .lock_loss_count (lock_loss_count),
    .fail            (fail)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got still running, want finished");
    $fatal(1);
  end

  typedef struct {
    int         len;
    logic       lock;
    logic       pll;
    logic [2:0] sys;
    logic       rdy;
    logic [7:0] retry;
    logic [7:0] loss;
  } vec_t;

  vec_t tbl [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic e_pll, input logic [2:0] e_sys,
                       input logic e_rdy, input logic [7:0] e_retry, input logic [7:0] e_loss,
                       input logic e_fail);
    n_tests++;
    if ({pll_reset, sys_reset, ready, retry_count, lock_loss_count, fail} !==
        {e_pll, e_sys, e_rdy, e_retry, e_loss, e_fail}) begin
      n_fail++;
      $display("FAIL %s: got pll=%b sys=%b rdy=%b retry=%0d loss=%0d fail=%b, want pll=%b sys=%b rdy=%b retry=%0d loss=%0d fail=%b",
               name, pll_reset, sys_reset, ready, retry_count, lock_loss_count, fail,
               e_pll, e_sys, e_rdy, e_retry, e_loss, e_fail);
    end
  endtask

  // assert reset between edges, check reset values, then release it right after an edge
  task automatic reset_dut(input string name);
    #3;
    reset = 1'b1;
    #1;
    check({name, "_reset_values"}, 1'b1, 3'b111, 1'b0, 8'd0, 8'd0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic       e_pll, e_rdy, e_fail;
  logic [2:0] e_sys;
  logic [7:0] e_retry, e_loss;

  initial begin
    tbl[0]  = '{3,  1'b1, 1'b1, 3'b111, 1'b0, 8'd0, 8'd0};
    tbl[1]  = '{13, 1'b1, 1'b0, 3'b111, 1'b0, 8'd0, 8'd0};
    tbl[2]  = '{4,  1'b1, 1'b0, 3'b110, 1'b0, 8'd0, 8'd0};
    tbl[3]  = '{4,  1'b1, 1'b0, 3'b100, 1'b0, 8'd0, 8'd0};
    tbl[4]  = '{5,  1'b1, 1'b0, 3'b000, 1'b1, 8'd0, 8'd0};
    tbl[5]  = '{1,  1'b0, 1'b0, 3'b000, 1'b1, 8'd0, 8'd0};
    tbl[6]  = '{1,  1'b1, 1'b0, 3'b000, 1'b1, 8'd0, 8'd0};
    tbl[7]  = '{13, 1'b1, 1'b0, 3'b111, 1'b0, 8'd0, 8'd1};
    tbl[8]  = '{4,  1'b1, 1'b0, 3'b110, 1'b0, 8'd0, 8'd1};
    tbl[9]  = '{4,  1'b1, 1'b0, 3'b100, 1'b0, 8'd0, 8'd1};
    tbl[10] = '{5,  1'b1, 1'b0, 3'b000, 1'b1, 8'd0, 8'd1};

    // clean lock, then a one-cycle lock drop in RUN and ordered re-release
    tick();
    reset_dut("clean");
    for (int r = 0; r < 11; r++) begin
      lock = tbl[r].lock;
      for (int c = 0; c < tbl[r].len; c++) begin
        tick();
        check($sformatf("vec%0d_cyc%0d", r, c), tbl[r].pll, tbl[r].sys, tbl[r].rdy,
              tbl[r].retry, tbl[r].loss, 1'b0);
      end
    end

    // async reset mid-RUN: values change with no clock edge
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_run", 1'b1, 3'b111, 1'b0, 8'd0, 8'd0, 1'b0);
    tick();

    // glitchy lock during STABLE restarts qualification
    reset_dut("glitch");
    lock = 1'b0;
    for (int n = 1; n <= 36; n++) begin
      lock = ((n >= 7 && n <= 11) || n >= 13);
      tick();
      e_pll = (n <= 3);
      e_sys = (n < 27) ? 3'b111 : (n < 31) ? 3'b110 : (n < 35) ? 3'b100 : 3'b000;
      e_rdy = (n >= 35);
      check($sformatf("glitch_edge%0d", n), e_pll, e_sys, e_rdy, 8'd0, 8'd0, 1'b0);
    end

    // lock loss after sys_reset[0] released, then timeout from WAIT_LOCK
    tick();
    reset_dut("midrel");
    for (int n = 1; n <= 52; n++) begin
      lock = (n <= 17);
      tick();
      e_pll   = (n <= 3) || (n == 52);
      e_sys   = (n >= 17 && n <= 19) ? 3'b110 : 3'b111;
      e_loss  = (n >= 20) ? 8'd1 : 8'd0;
      e_retry = (n >= 52) ? 8'd1 : 8'd0;
      check($sformatf("midrel_edge%0d", n), e_pll, e_sys, 1'b0, e_retry, e_loss, 1'b0);
    end

    // no lock: repeated PLL retries every 36 cycles
    tick();
    reset_dut("nolock");
    lock = 1'b0;
    for (int n = 1; n <= 110; n++) begin
      tick();
      e_pll   = ((n % 36) <= 3);
      e_retry = 8'(n / 36);
      e_fail  = 1'b0;
`ifdef RSTSEQ_RETRY_LIMIT_EN
      if (n >= 72) begin
        e_pll   = 1'b1;
        e_retry = 8'd2;
        e_fail  = 1'b1;
      end
`endif
      check($sformatf("nolock_edge%0d", n), e_pll, 3'b111, 1'b0, e_retry, 8'd0, e_fail);
    end

    // async reset clears retry_count (and fail) immediately
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_retry", 1'b1, 3'b111, 1'b0, 8'd0, 8'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
